// File: rtl/fir_tap_sequencer.sv
// Multi-channel FIR tap sequencer: coefficient/delay-line addressing and MAC framing.
// Optional FIR_SEQ_SYMMETRIC_EN folds coef_addr_out for symmetric coefficient ROMs.
module fir_tap_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_TAPS   = 64,
    parameter int N_CH       = 2,
    parameter int CH_WIDTH   = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [ADDR_WIDTH-1:0] taps_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  valid_out,
    output logic                  first_out,
    output logic                  last_out,
    output logic [CH_WIDTH-1:0]   ch_out,
    output logic [ADDR_WIDTH-1:0] tap_out,
    output logic [ADDR_WIDTH-1:0] coef_addr_out,
    output logic [ADDR_WIDTH-1:0] data_addr_out,
    output logic [ADDR_WIDTH-1:0] wr_ptr_out
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] MAX_A  = ADDR_WIDTH'(MAX_TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_P = ADDR_WIDTH'(MAX_TAPS - 1);
    localparam logic [CH_WIDTH-1:0]   LAST_C = CH_WIDTH'(N_CH - 1);
    localparam logic [CH_WIDTH-1:0]   CH_ONE = CH_WIDTH'(1);

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] t_q, t_d;
    logic [ADDR_WIDTH-1:0] k_q, k_d;
    logic [CH_WIDTH-1:0]   ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] coef_q, coef_d;
    logic valid_q, valid_d;
    logic first_q, first_d;
    logic last_q, last_d;
    logic done_q, done_d;
    logic busy_q, busy_d;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] t_new;
    logic [ADDR_WIDTH-1:0] wr_inc;

    // Circular delay-line read address: sample k taps older than wr.
    function automatic logic [ADDR_WIDTH-1:0] ring_addr(
        input logic [ADDR_WIDTH-1:0] wr,
        input logic [ADDR_WIDTH-1:0] k
    );
        if (wr >= k) begin
            return wr - k;
        end
        return wr + (MAX_A - k);
    endfunction

`ifdef FIR_SEQ_SYMMETRIC_EN
    // Mirror the upper half of the taps onto the stored lower half.
    function automatic logic [ADDR_WIDTH-1:0] fold_addr(
        input logic [ADDR_WIDTH-1:0] k,
        input logic [ADDR_WIDTH-1:0] t
    );
        logic [ADDR_WIDTH-1:0] half;
        half = (t >> 1) + {{(ADDR_WIDTH-1){1'b0}}, t[0]};
        if (k < half) begin
            return k;
        end
        return t - ONE - k;
    endfunction
`endif

    // Tap count clamp and write-pointer increment for a new sample.
    always_comb begin
        t_new = taps_in;
        if (taps_in == '0) begin
            t_new = ONE;
        end else if (taps_in > MAX_A) begin
            t_new = MAX_A;
        end
        wr_inc = (wr_q == LAST_P) ? '0 : wr_q + ONE;
    end

    // Next-state and next-output logic; outputs describe the tap of the next cycle.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        ch_d    = ch_q;
        wr_d    = wr_q;
        data_d  = data_q;
        coef_d  = coef_q;
        valid_d = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        accept  = start_in && (state_q != RUN);

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = RUN;
                    t_d     = t_new;
                    wr_d    = wr_inc;
                    k_d     = '0;
                    ch_d    = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                busy_d = 1'b1;
                if (k_q == t_q - ONE) begin
                    if (ch_q == LAST_C) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        k_d  = '0;
                        ch_d = ch_q + CH_ONE;
                    end
                end else begin
                    k_d = k_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == RUN) begin
            valid_d = 1'b1;
            first_d = (k_d == '0);
            last_d  = (k_d == t_d - ONE);
            data_d  = ring_addr(wr_d, k_d);
`ifdef FIR_SEQ_SYMMETRIC_EN
            coef_d  = fold_addr(k_d, t_d);
`else
            coef_d  = k_d;
`endif
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, pointer and registered output state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            t_q     <= '0;
            k_q     <= '0;
            ch_q    <= '0;
            wr_q    <= '0;
            data_q  <= '0;
            coef_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            t_q     <= t_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            coef_q  <= coef_d;
            valid_q <= valid_d;
            first_q <= first_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign busy_out      = busy_q;
    assign done_out      = done_q;
    assign valid_out     = valid_q;
    assign first_out     = first_q;
    assign last_out      = last_q;
    assign ch_out        = ch_q;
    assign tap_out       = k_q;
    assign coef_addr_out = coef_q;
    assign data_addr_out = data_q;
    assign wr_ptr_out    = wr_q;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: a queue of cycle-stamped expected
// events is filled at start time and drained by an independent monitor.
module tb_fir_tap_sequencer;

    localparam int AW = 8;
    localparam int MT = 64;
    localparam int NC = 2;
    localparam int CW = 1;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          start_in = 1'b0;
    logic [AW-1:0] taps_in = '0;
    logic          busy_out, done_out, valid_out, first_out, last_out;
    logic [CW-1:0] ch_out;
    logic [AW-1:0] tap_out, coef_addr_out, data_addr_out, wr_ptr_out;

    fir_tap_sequencer #(
        .ADDR_WIDTH(AW), .MAX_TAPS(MT), .N_CH(NC), .CH_WIDTH(CW)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .taps_in(taps_in), .busy_out(busy_out), .done_out(done_out),
        .valid_out(valid_out), .first_out(first_out), .last_out(last_out),
        .ch_out(ch_out), .tap_out(tap_out), .coef_addr_out(coef_addr_out),
        .data_addr_out(data_addr_out), .wr_ptr_out(wr_ptr_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int kind;
        int cyc;
        int ch;
        int k;
        int first;
        int last;
        int data;
        int coef;
        int wr;
    } ev_t;

    ev_t q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_err = 0;
    int  wr_m = 0;
    bit  mon_en = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic int coef_m(input int k, input int t);
`ifdef FIR_SEQ_SYMMETRIC_EN
        if (k < (t + 1) / 2) return k;
        return t - 1 - k;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string nm, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, want);
        end
    endtask

    // Expected response of one accepted start, stamped with absolute cycles.
    task automatic issue(input int taps, output int t);
        ev_t e;
        int  base;
        t = (taps == 0) ? 1 : ((taps > MT) ? MT : taps);
        wr_m = (wr_m + 1) % MT;
        base = cyc + 1;
        for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < t; k++) begin
                e.kind = 0; e.cyc = base + c * t + k;
                e.ch = c; e.k = k;
                e.first = (k == 0); e.last = (k == t - 1);
                e.data = (wr_m - k + MT) % MT;
                e.coef = coef_m(k, t); e.wr = wr_m;
                q.push_back(e);
            end
        end
        e = '{kind: 1, cyc: base + NC * t, ch: 0, k: 0, first: 0,
              last: 0, data: 0, coef: 0, wr: wr_m};
        q.push_back(e);
    endtask

    // Called at a negedge while the DUT is IDLE or DONE; returns at the
    // negedge of the DONE cycle.
    task automatic seq(input int taps, input bit poke);
        int t, n;
        start_in = 1'b1;
        taps_in  = AW'(taps);
        issue(taps, t);
        @(negedge clk_in);
        start_in = 1'b0;
        taps_in  = AW'($urandom);
        n = NC * t;
        for (int i = 0; i < n; i++) begin
            start_in = (poke && i == n / 2);
            @(negedge clk_in);
        end
        start_in = 1'b0;
    endtask

    task automatic idle_gap();
        ev_t e;
        e = '{kind: 2, cyc: cyc + 1, ch: 0, k: 0, first: 0,
              last: 0, data: 0, coef: 0, wr: wr_m};
        q.push_back(e);
        @(negedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, int'(valid_out), 0);
        chk({tag, "_first"}, int'(first_out), 0);
        chk({tag, "_last"}, int'(last_out), 0);
        chk({tag, "_done"}, int'(done_out), 0);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_ch"}, int'(ch_out), 0);
        chk({tag, "_tap"}, int'(tap_out), 0);
        chk({tag, "_coef"}, int'(coef_addr_out), 0);
        chk({tag, "_data"}, int'(data_addr_out), 0);
        chk({tag, "_wr"}, int'(wr_ptr_out), 0);
    endtask

    // Monitor: match each presented output against the cycle-stamped queue.
    always @(negedge clk_in) begin
        ev_t e;
        bit  ok;
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                n_cmp++; n_err++;
                $display("FAIL missed kind=%0d at cyc %0d (now %0d)",
                         e.kind, e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.kind == 0) begin
                    ok = valid_out && busy_out && !done_out &&
                         int'(ch_out) == e.ch && int'(tap_out) == e.k &&
                         int'(first_out) == e.first &&
                         int'(last_out) == e.last &&
                         int'(data_addr_out) == e.data &&
                         int'(coef_addr_out) == e.coef &&
                         int'(wr_ptr_out) == e.wr;
                end else if (e.kind == 1) begin
                    ok = done_out && busy_out && !valid_out &&
                         !first_out && !last_out &&
                         int'(wr_ptr_out) == e.wr;
                end else begin
                    ok = !done_out && !busy_out && !valid_out &&
                         !first_out && !last_out &&
                         int'(wr_ptr_out) == e.wr;
                end
                if (!ok) begin
                    n_err++;
                    $display({"FAIL ev kind=%0d cyc=%0d got v=%0d d=%0d b=%0d ",
                              "ch=%0d k=%0d f=%0d l=%0d da=%0d ca=%0d wr=%0d ",
                              "expected ch=%0d k=%0d f=%0d l=%0d da=%0d ca=%0d wr=%0d"},
                             e.kind, cyc, valid_out, done_out, busy_out,
                             ch_out, tap_out, first_out, last_out,
                             data_addr_out, coef_addr_out, wr_ptr_out,
                             e.ch, e.k, e.first, e.last, e.data, e.coef, e.wr);
                end
            end else if (valid_out || done_out) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected output at cyc %0d: valid %0d done %0d",
                         cyc, valid_out, done_out);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk_zero("reset");
        rst_in = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_in);

        // Directed: T=5 then single-tap and clamped sequences.
        seq(5, 0);
        idle_gap();
        seq(0, 0);
        idle_gap();
        seq(200, 0);
        idle_gap();

        // Start pulses during RUN must be ignored.
        seq(7, 1);
        idle_gap();

        // Back-to-back starts held through DONE, wrapping wr_ptr.
        for (int i = 0; i < 64; i++) begin
            seq(int'($urandom_range(0, 4)), 0);
        end
        idle_gap();

        // Randomized mix of tap counts, gaps and RUN pokes.
        for (int i = 0; i < 30; i++) begin
            seq(int'($urandom_range(0, 90)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_gap();
        end
        idle_gap();

        // Reset in the middle of RUN aborts without a done pulse.
        begin
            int t;
            start_in = 1'b1;
            taps_in  = AW'(9);
            issue(9, t);
            @(negedge clk_in);
            start_in = 1'b0;
            repeat (6) @(negedge clk_in);
            mon_en = 1'b0;
            rst_in = 1'b0;
            #1;
            chk_zero("abort");
            q.delete();
            wr_m = 0;
            @(negedge clk_in);
            rst_in = 1'b1;
            mon_en = 1'b1;
            repeat (3) @(negedge clk_in);
        end
        seq(5, 0);
        idle_gap();
        repeat (2) @(negedge clk_in);

        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Multi-channel tap sequencer for the FIR datapath: on each new-sample `start_in` it walks every channel through a runtime-programmable number of taps and emits per-cycle coefficient and delay-line addresses plus accumulator framing strobes. It replaces the single-channel, fixed-length coefficient counter. It sits between the ADC sample strobe and the coefficient ROM / sample RAM / MAC pipeline, and adds a start/busy/done handshake and circular delay-line addressing.

## Interface
- `ADDR_WIDTH`, 8, width of tap count, tap index and addresses; must satisfy 2^ADDR_WIDTH > MAX_TAPS
- `MAX_TAPS`, 64, delay-line depth and tap-count ceiling, ≥ 2
- `N_CH`, 2, channels sequenced per start, ≥ 1
- `CH_WIDTH`, 1, channel index width, = max(1, clog2(N_CH))
- `clk_in`  input  1  clock
- `rst_in`  input  1  reset, asynchronous, active-low
- `start_in`  input  1  new-sample request; level-sampled
- `taps_in`  input  ADDR_WIDTH  tap count; sampled only when start is accepted
- `busy_out`  output  1  sequence in progress (RUN or DONE)
- `done_out`  output  1  one-cycle pulse after the last tap of the last channel
- `valid_out`  output  1  address outputs valid this cycle
- `first_out`  output  1  tap 0 of a channel; MAC clears the accumulator
- `last_out`  output  1  final tap of a channel; MAC writes the result
- `ch_out`  output  CH_WIDTH  current channel
- `tap_out`  output  ADDR_WIDTH  current tap index k
- `coef_addr_out`  output  ADDR_WIDTH  coefficient ROM address
- `data_addr_out`  output  ADDR_WIDTH  sample RAM address, (wr_ptr − k) mod MAX_TAPS
- `wr_ptr_out`  output  ADDR_WIDTH  delay-line write pointer for the incoming sample

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset values: all outputs are 0, state is IDLE, and the wr_ptr register is 0. Asserting reset mid-sequence aborts immediately with no done pulse.
- Start acceptance: a start is accepted when `start_in`=1 while in IDLE or DONE. `start_in` is ignored in RUN.
- On an accepted start:
  - Latch the tap count T: `taps_in`=0 becomes 1; values above MAX_TAPS are clamped to MAX_TAPS.
  - Advance wr_ptr to wr_ptr+1, wrapping MAX_TAPS−1 → 0.
  - Set ch=0 and k=0, then go to RUN.
- RUN, each cycle:
  - Drive valid_out=1, ch_out=ch, tap_out=k, first_out=(k==0), last_out=(k==T−1).
  - Drive data_addr_out = wr_ptr−k if wr_ptr ≥ k, else wr_ptr+MAX_TAPS−k.
  - Advance k. At k==T−1, set k=0 and ch=ch+1.
  - At ch==N_CH−1 and k==T−1, go to DONE.
- DONE: hold for one cycle with done_out=1, valid_out=0, busy_out=1. Then go to IDLE, or to RUN if a start is accepted in that cycle.
- In IDLE and DONE, valid_out, first_out and last_out are 0. The address outputs hold their last values.
- T=1: first_out and last_out are both 1 on every tap.

## Timing
- A start accepted at edge E produces the first valid tap (ch 0, k 0) in the cycle after E.
- A sequence has N_CH·T valid cycles, followed by done_out in the next cycle.
- Back-to-back throughput is N_CH·T+1 cycles per sample. This requires start_in to be held or re-asserted during DONE.
- wr_ptr_out updates in the same cycle as the first valid tap. It is stable for the whole sequence and after it.
- Registered latency from the state/counters to all outputs is 0 cycles. Downstream ROM/RAM read latency is absorbed by the MAC pipeline, not by this block.
- busy_out rises with the first valid cycle and falls the cycle after done_out, unless a back-to-back start is accepted.

## Configuration
- `FIR_SEQ_SYMMETRIC_EN` defined: symmetric-coefficient folding. coef_addr_out = k for k < ceil(T/2), otherwise T−1−k, so the ROM stores only ceil(T/2) coefficients.
- `FIR_SEQ_SYMMETRIC_EN` undefined: coef_addr_out = k. No folding logic is synthesised.
- In both cases, data addressing and framing are unchanged.

## Test plan
- Reset then start, with MAX_TAPS=64, N_CH=2, taps_in=5:
  - wr_ptr_out=1.
  - 10 valid cycles: ch 0 then 1, k 0..4.
  - data_addr_out sequence 1,0,63,62,61 per channel.
  - first/last strobes on k=0 and k=4.
  - done_out in cycle 11, busy_out low in cycle 12.
- taps_in=0 -> T=1: 2 valid cycles, each with first_out=last_out=1. taps_in=200 -> T=64: 128 valid cycles.
- Pulse start_in in RUN -> no effect. Hold start_in through DONE -> next sequence begins the cycle after done_out, and wr_ptr_out increments by 1.
- 64 consecutive starts -> wr_ptr_out wraps from 63 to 0, and data_addr_out wraps correctly across the boundary.
- Drop rst_in mid-RUN -> all outputs 0 immediately, no done pulse. After release, a start behaves as in the first scenario.
- With `FIR_SEQ_SYMMETRIC_EN`, T=5: coef_addr_out = 0,1,2,1,0. T=4: 0,1,1,0. Without the macro, T=5: 0,1,2,3,4.
